// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU self-test path: MISR seed and taps, FSM
// state encoding, the ALU response bundle and its packing into a MISR word.
package alu_bist_pkg;

  localparam int unsigned MISR_W = 32;
  localparam logic [MISR_W-1:0] MISR_SEED = 32'hFFFF_FFFF;

  // Feedback taps for x^32 + x^22 + x^2 + x + 1
  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [MISR_W-1:0] r;
    logic              zero;
    logic              ovf;
    logic              branch;
  } alu_bundle_t;

  // Flags land in the low bits so each one perturbs a distinct MISR stage
  function automatic logic [MISR_W-1:0] pack_data(input alu_bundle_t b);
    return b.r ^ {29'd0, b.branch, b.ovf, b.zero};
  endfunction

endpackage

// File: rtl/alu_resp_misr_if.sv
// ALU response bundle as seen by the compactor.
//   valid_in  : bundle is a valid vector this cycle
//   r_in      : ALU result
//   zero_in, ovf_in, branch_in : ALU flags
// master drives the bundle (ALU side), slave samples it (compactor).
interface alu_resp_misr_if;
  import alu_bist_pkg::*;

  logic              valid_in;
  logic [MISR_W-1:0] r_in;
  logic              zero_in;
  logic              ovf_in;
  logic              branch_in;

  modport master (
    output valid_in, r_in, zero_in, ovf_in, branch_in
  );

  modport slave (
    input valid_in, r_in, zero_in, ovf_in, branch_in
  );
endinterface

// File: rtl/misr32.sv
// Combinational next-state of the 32-bit MISR.
//   sig      : current signature
//   d        : data word folded in this step
//   sig_next : shifted signature with feedback, xored with d
module misr32
  import alu_bist_pkg::*;
(
  input  logic [MISR_W-1:0] sig,
  input  logic [MISR_W-1:0] d,
  output logic [MISR_W-1:0] sig_next
);

  logic fb;

  assign fb       = sig[TAP_A] ^ sig[TAP_B] ^ sig[TAP_C] ^ sig[TAP_D];
  assign sig_next = {sig[MISR_W-2:0], fb} ^ d;

endmodule

// File: rtl/alu_resp_misr.sv
// Response compactor: folds NUM_VEC accepted ALU bundles into a MISR and
// compares the final signature with a golden value latched at start.
//   clk, reset : clock, synchronous active-high reset
//   start      : pulse, begins a run from IDLE or DONE
//   golden     : expected final signature, sampled with start
//   vec        : ALU response bundle (slave modport)
//   busy       : run in progress
//   done       : run finished, held until next start/reset
//   pass       : final signature matched golden (valid while done)
//   signature  : current MISR contents
//   count      : vectors accepted in the current run
module alu_resp_misr
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VEC = 1000,
  parameter int unsigned CNT_W   = $clog2(NUM_VEC + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MISR_W-1:0]   golden,
  alu_resp_misr_if.slave      vec,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [MISR_W-1:0]   signature,
  output logic [CNT_W-1:0]    count
);

  state_t            state;
  logic [MISR_W-1:0] golden_q;
  alu_bundle_t       bundle_c;
  logic [MISR_W-1:0] data_c;
  logic [MISR_W-1:0] sig_next_c;
  logic              last_c;

  assign bundle_c = '{r: vec.r_in, zero: vec.zero_in, ovf: vec.ovf_in,
                      branch: vec.branch_in};
  assign data_c   = pack_data(bundle_c);
  // This vector completes the run
  assign last_c   = (count == CNT_W'(NUM_VEC - 1));

  misr32 u_misr (
    .sig      (signature),
    .d        (data_c),
    .sig_next (sig_next_c)
  );

  // Run control, compaction, golden latch and final compare
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      count     <= '0;
      golden_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= MISR_SEED;
            count     <= '0;
            golden_q  <= golden;
          end
        end
        RUN: begin
          if (vec.valid_in) begin
            signature <= sig_next_c;
            count     <= count + CNT_W'(1);
            if (last_c) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next_c == golden_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_resp_misr.sv
// Self-checking bench for alu_resp_misr: a 1000-vector instance checked every
// cycle against a behavioural model, plus 1- and 2-vector instances with
// hand-computed signatures.
module tb_alu_resp_misr;

  localparam int N = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Main instance (NUM_VEC = 1000)
  alu_resp_misr_if ifm ();
  logic        start_m = 1'b0;
  logic [31:0] golden_m = '0;
  logic        busy_m, done_m, pass_m;
  logic [31:0] sig_m;
  logic [9:0]  count_m;

  alu_resp_misr #(.NUM_VEC(N)) dut_m (
    .clk(clk), .reset(reset), .start(start_m), .golden(golden_m), .vec(ifm.slave),
    .busy(busy_m), .done(done_m), .pass(pass_m), .signature(sig_m), .count(count_m)
  );

  // NUM_VEC = 1 instance
  alu_resp_misr_if if1 ();
  logic        start_1 = 1'b0;
  logic [31:0] golden_1 = '0;
  logic        busy_1, done_1, pass_1;
  logic [31:0] sig_1;
  logic [0:0]  count_1;

  alu_resp_misr #(.NUM_VEC(1)) dut_1 (
    .clk(clk), .reset(reset), .start(start_1), .golden(golden_1), .vec(if1.slave),
    .busy(busy_1), .done(done_1), .pass(pass_1), .signature(sig_1), .count(count_1)
  );

  // NUM_VEC = 2 instance
  alu_resp_misr_if if2 ();
  logic        start_2 = 1'b0;
  logic [31:0] golden_2 = '0;
  logic        busy_2, done_2, pass_2;
  logic [31:0] sig_2;
  logic [1:0]  count_2;

  alu_resp_misr #(.NUM_VEC(2)) dut_2 (
    .clk(clk), .reset(reset), .start(start_2), .golden(golden_2), .vec(if2.slave),
    .busy(busy_2), .done(done_2), .pass(pass_2), .signature(sig_2), .count(count_2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Polynomial x^32+x^22+x^2+x+1: feedback is the parity of the tapped bits
  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [31:0] d);
    logic fb;
    fb = ^(s & 32'h8020_0003);
    return ((s << 1) | {31'd0, fb}) ^ d;
  endfunction

  // Stimulus store: r and flags {branch, ovf, zero}
  logic [31:0] vr [N];
  logic [2:0]  vf [N];

  function automatic logic [31:0] fold_all();
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < N; i++) s = m_step(s, vr[i] ^ {29'd0, vf[i]});
    return s;
  endfunction

  // Behavioural model of the 1000-vector instance
  bit          m_run, m_done, m_pass;
  logic [31:0] m_sig, m_gold;
  int          m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_run <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0;
      m_sig <= '0; m_gold <= '0; m_cnt <= 0;
    end else if (!m_run && start_m) begin
      m_run <= 1'b1; m_done <= 1'b0; m_pass <= 1'b0;
      m_sig <= 32'hFFFF_FFFF; m_gold <= golden_m; m_cnt <= 0;
    end else if (m_run && ifm.valid_in) begin
      m_sig <= m_step(m_sig, ifm.r_in ^ {29'd0, ifm.branch_in, ifm.ovf_in, ifm.zero_in});
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == N) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_pass <= (m_step(m_sig, ifm.r_in ^ {29'd0, ifm.branch_in, ifm.ovf_in, ifm.zero_in}) == m_gold);
      end
    end
  end

  // Per-cycle comparison of the main instance against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy", {31'd0, busy_m}, {31'd0, m_run});
      chk("done", {31'd0, done_m}, {31'd0, m_done});
      chk("pass", {31'd0, pass_m}, {31'd0, m_pass});
      chk("signature", sig_m, m_sig);
      chk("count", {22'd0, count_m}, 32'(m_cnt));
    end
  end

  // Drive a full or partial run on the main instance; idle gaps carry junk
  // data and stray start pulses that must be ignored.
  task automatic run_main(input logic [31:0] g, input int flip, input int stop_at,
                          input bit start_on_last);
    start_m  = 1'b1;
    golden_m = g;
    @(negedge clk);
    start_m  = 1'b0;
    golden_m = $urandom;
    chk("start_sig", sig_m, 32'hFFFF_FFFF);
    chk("start_busy", {31'd0, busy_m}, 32'd1);
    chk("start_done", {31'd0, done_m}, 32'd0);
    for (int i = 0; i < stop_at; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        ifm.valid_in = 1'b0;
        ifm.r_in     = $urandom;
        start_m      = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      ifm.valid_in = 1'b1;
      ifm.r_in     = vr[i];
      {ifm.branch_in, ifm.ovf_in, ifm.zero_in} = vf[i] ^ ((i == flip) ? 3'b010 : 3'b000);
      start_m      = start_on_last && (i == N - 1);
      @(negedge clk);
    end
    ifm.valid_in = 1'b0;
    start_m      = 1'b0;
    {ifm.branch_in, ifm.ovf_in, ifm.zero_in} = 3'b000;
  endtask

  // Valid pulses with no run active must not disturb anything
  task automatic stray_valids(input int n);
    for (int i = 0; i < n; i++) begin
      ifm.valid_in = $urandom_range(0, 1) == 1;
      ifm.r_in     = $urandom;
      {ifm.branch_in, ifm.ovf_in, ifm.zero_in} = 3'($urandom);
      @(negedge clk);
    end
    ifm.valid_in = 1'b0;
  endtask

  task automatic vec1(input logic [31:0] r, input logic [2:0] f);
    start_1  = 1'b1;
    golden_1 = 32'hFFFF_FFFE;
    @(negedge clk);
    start_1 = 1'b0;
    if1.valid_in = 1'b1;
    if1.r_in = r;
    {if1.branch_in, if1.ovf_in, if1.zero_in} = f;
    @(negedge clk);
    if1.valid_in = 1'b0;
  endtask

  logic [31:0] gold;
  int busy_cycles;

  initial begin
    ifm.valid_in = 1'b0; ifm.r_in = '0; ifm.zero_in = 1'b0; ifm.ovf_in = 1'b0; ifm.branch_in = 1'b0;
    if1.valid_in = 1'b0; if1.r_in = '0; if1.zero_in = 1'b0; if1.ovf_in = 1'b0; if1.branch_in = 1'b0;
    if2.valid_in = 1'b0; if2.r_in = '0; if2.zero_in = 1'b0; if2.ovf_in = 1'b0; if2.branch_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    chk("rst_sig", sig_m, 32'h0);
    chk("rst_busy", {31'd0, busy_m}, 32'd0);
    chk("rst_done", {31'd0, done_m}, 32'd0);
    chk("rst_count", {22'd0, count_m}, 32'd0);

    // Pin the model polynomial to hand-computed steps
    chk("model_step1", m_step(32'hFFFF_FFFF, 32'h0), 32'hFFFF_FFFE);
    chk("model_step2", m_step(32'hFFFF_FFFE, 32'h0), 32'hFFFF_FFFD);

    // Single zero vector matches golden
    vec1(32'h0, 3'b000);
    chk("n1_sig", sig_1, 32'hFFFF_FFFE);
    chk("n1_done", {31'd0, done_1}, 32'd1);
    chk("n1_pass", {31'd0, pass_1}, 32'd1);
    chk("n1_busy", {31'd0, busy_1}, 32'd0);
    chk("n1_count", {31'd0, count_1}, 32'd1);
    // zero flag perturbs bit 0 -> mismatch
    vec1(32'h0, 3'b001);
    chk("n1z_sig", sig_1, 32'hFFFF_FFFF);
    chk("n1z_pass", {31'd0, pass_1}, 32'd0);
    chk("n1z_done", {31'd0, done_1}, 32'd1);
    // r=1 has the same effect
    vec1(32'h1, 3'b000);
    chk("n1r_sig", sig_1, 32'hFFFF_FFFF);
    chk("n1r_pass", {31'd0, pass_1}, 32'd0);

    // Two zero vectors separated by three idle cycles
    start_2  = 1'b1;
    golden_2 = 32'hFFFF_FFFD;
    @(negedge clk);
    start_2 = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy_2) busy_cycles++;
      if2.valid_in = (k == 0) || (k == 4);
      @(negedge clk);
    end
    if2.valid_in = 1'b0;
    chk("n2_busy_cycles", 32'(busy_cycles), 32'd5);
    chk("n2_sig", sig_2, 32'hFFFF_FFFD);
    chk("n2_count", {30'd0, count_2}, 32'd2);
    chk("n2_pass", {31'd0, pass_2}, 32'd1);
    chk("n2_done", {31'd0, done_2}, 32'd1);

    // Random stimulus stream
    void'($urandom(1));
    for (int i = 0; i < N; i++) begin
      vr[i] = $urandom;
      vf[i] = 3'($urandom);
    end
    gold = fold_all();

    stray_valids(8);
    run_main(gold, -1, N, 1'b1);
    chk("clean_pass", {31'd0, pass_m}, 32'd1);
    chk("clean_done", {31'd0, done_m}, 32'd1);
    chk("clean_sig", sig_m, gold);
    stray_valids(8);

    // Restart from DONE with one ovf bit flipped
    run_main(gold, 437, N, 1'b0);
    chk("flip_pass", {31'd0, pass_m}, 32'd0);
    chk("flip_done", {31'd0, done_m}, 32'd1);

    // Abort halfway with reset
    run_main(gold, -1, 500, 1'b0);
    chk("half_count", {22'd0, count_m}, 32'd500);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_sig", sig_m, 32'h0);
    chk("abort_busy", {31'd0, busy_m}, 32'd0);
    chk("abort_count", {22'd0, count_m}, 32'd0);
    stray_valids(4);
    run_main(gold, -1, N, 1'b0);
    chk("rerun_pass", {31'd0, pass_m}, 32'd1);
    chk("rerun_sig", sig_m, gold);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
